// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  // Instruction field positions
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM16_MSB  = 15;
  localparam int unsigned IMM16_LSB  = 0;
  localparam int unsigned ADDR26_MSB = 25;
  localparam int unsigned ADDR26_LSB = 0;

  // Opcodes shared with the main decoder
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Branch displacement: sign-extended imm16 scaled to a byte offset
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC selection: jump beats branch beats sequential.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_instr,
  input  logic            i_pc_src,
  input  logic            i_jump,
  output logic [XLEN-1:0] o_next_pc_c
);

  logic [XLEN-1:0] w_branch_tgt;
  logic [XLEN-1:0] w_jump_tgt;
  logic [5:0]      w_unused_bits;

  assign w_branch_tgt  = i_pc_plus4 + branch_offset(i_instr[IMM16_MSB:IMM16_LSB]);
  assign w_jump_tgt    = {i_pc_plus4[31:28], i_instr[ADDR26_MSB:ADDR26_LSB], 2'b00};
  assign w_unused_bits = i_instr[OPCODE_MSB:OPCODE_LSB];

  // Priority select of the next PC
  always_comb begin
    o_next_pc_c = i_pc_plus4;
    if (i_jump) begin
      o_next_pc_c = w_jump_tgt;
    end else if (i_pc_src) begin
      o_next_pc_c = w_branch_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem handshake, instruction latch, next-PC commit.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        pc_src,
  input  logic        jump,
  input  logic        retire,
  output logic        fetch_err
);

  localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~32'h3;

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_instr;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_req;
  logic             r_valid;
  logic             r_fetch_err;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_cnt_inc  = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

  next_pc_calc u_next_pc (
    .i_pc_plus4  (w_pc_plus4),
    .i_instr     (r_instr),
    .i_pc_src    (pc_src),
    .i_jump      (jump),
    .o_next_pc_c (w_next_pc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = ST_FETCH;
      ST_FETCH: if (imem_ready) w_state_next = ST_HOLD;
      ST_HOLD:  if (retire) w_state_next = ST_FETCH;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_req   <= (w_state_next == ST_FETCH);
      r_valid <= (w_state_next == ST_HOLD);
    end
  end

  // PC, instruction latch, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= PC_INIT;
      r_instr     <= '0;
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_instr    <= imem_rdata;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_cnt_inc;
            if ((TIMEOUT_CYCLES != 0) && (32'(w_cnt_inc) >= TIMEOUT_CYCLES)) begin
              r_fetch_err <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (retire) begin
            r_pc       <= w_next_pc;
            r_wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign funct       = r_instr[FUNCT_MSB:FUNCT_LSB];
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fetch_err   = r_fetch_err;

endmodule
